// File: rtl/m_prog_loader_if.sv
// m_prog_loader_if: start/length, byte stream and memory write port of the program loader.
interface m_prog_loader_if #(parameter int ADDR_W = 11, parameter int LEN_W = 12);
  logic              w_start;
  logic [LEN_W-1:0]  w_len;
  logic              w_bvalid;
  logic [7:0]        w_bdata;
  logic              r_bready;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_din;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_proc_rst;
  modport slave (
    input  w_start, w_len, w_bvalid, w_bdata,
    output r_bready, r_addr, r_we, r_din, r_busy, r_done, r_err, r_proc_rst
  );
  modport master (
    output w_start, w_len, w_bvalid, w_bdata,
    input  r_bready, r_addr, r_we, r_din, r_busy, r_done, r_err, r_proc_rst
  );
endinterface

// File: rtl/m_prog_loader.sv
// m_prog_loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional CHECKSUM_EN: one trailing XOR checksum byte is accepted per load and flagged on r_err.
module m_prog_loader #(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 12
) (
  input logic             w_clk,
  input logic             w_rst,
  m_prog_loader_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
`ifdef CHECKSUM_EN
    CSUM,
`endif
    DONE
  } state_t;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;
  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_wcnt;
  logic [1:0]       r_bcnt;
`ifdef CHECKSUM_EN
  logic [7:0]       r_csum;
`endif
  logic [LEN_W-1:0] w_len_cl;
  logic [LEN_W-1:0] w_wcnt_nx;
  logic             w_xfer;
  assign w_len_cl  = (bus.w_len > MAX_LEN) ? MAX_LEN : bus.w_len;
  assign w_wcnt_nx = r_wcnt + LEN_W'(1);
  assign w_xfer    = bus.w_bvalid && bus.r_bready;
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_wcnt         <= '0;
      r_bcnt         <= '0;
`ifdef CHECKSUM_EN
      r_csum         <= '0;
`endif
      bus.r_bready   <= 1'b0;
      bus.r_addr     <= '0;
      bus.r_we       <= 1'b0;
      bus.r_din      <= '0;
      bus.r_busy     <= 1'b0;
      bus.r_done     <= 1'b0;
      bus.r_err      <= 1'b0;
      bus.r_proc_rst <= 1'b1;
    end else begin
      case (r_state)
        IDLE, DONE: if (bus.w_start) begin
          r_len      <= w_len_cl;
          r_wcnt     <= '0;
          r_bcnt     <= '0;
`ifdef CHECKSUM_EN
          r_csum     <= '0;
`endif
          bus.r_addr <= '0;
          bus.r_err  <= 1'b0;
          // A zero-length load completes immediately and frees the processor again
          r_state        <= (w_len_cl == '0) ? DONE : RECV;
          bus.r_done     <= (w_len_cl == '0);
          bus.r_busy     <= (w_len_cl != '0);
          bus.r_proc_rst <= (w_len_cl != '0);
          bus.r_bready   <= (w_len_cl != '0);
        end
        RECV: if (w_xfer) begin
          bus.r_din <= {bus.r_din[23:0], bus.w_bdata};
`ifdef CHECKSUM_EN
          r_csum    <= r_csum ^ bus.w_bdata;
`endif
          r_bcnt    <= r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            r_state      <= WRITE;
            bus.r_we     <= 1'b1;
            bus.r_bready <= 1'b0;
          end
        end
        WRITE: begin
          bus.r_we <= 1'b0;
          r_wcnt   <= w_wcnt_nx;
          if (w_wcnt_nx == r_len) begin
`ifdef CHECKSUM_EN
            r_state        <= CSUM;
            bus.r_bready   <= 1'b1;
`else
            r_state        <= DONE;
            bus.r_done     <= 1'b1;
            bus.r_busy     <= 1'b0;
            bus.r_proc_rst <= 1'b0;
`endif
          end else begin
            r_state      <= RECV;
            bus.r_addr   <= bus.r_addr + ADDR_W'(1);
            bus.r_bready <= 1'b1;
          end
        end
`ifdef CHECKSUM_EN
        CSUM: if (w_xfer) begin
          bus.r_err      <= (bus.w_bdata != r_csum);
          r_state        <= DONE;
          bus.r_bready   <= 1'b0;
          bus.r_done     <= 1'b1;
          bus.r_busy     <= 1'b0;
          bus.r_proc_rst <= 1'b0;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_prog_loader.sv
// tb_m_prog_loader: scoreboard bench; expected memory writes are queued by stimulus and checked by a monitor.
module tb_m_prog_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  m_prog_loader_if #(.ADDR_W(11), .LEN_W(12)) bus();
  m_prog_loader #(.ADDR_W(11), .LEN_W(12)) dut (.w_clk(clk), .w_rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [42:0] exp_q[$];
  logic [31:0] wbuf[2048];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    logic [42:0] e;
    if (bus.r_we === 1'b1) begin
      we_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got addr %h din %h want no write", bus.r_addr, bus.r_din);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {21'd0, bus.r_addr}, {21'd0, e[42:32]});
        chk("wr_din", bus.r_din, e[31:0]);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input int len);
    bus.w_start = 1'b1;
    bus.w_len   = 12'(len);
    tick();
    bus.w_start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.w_bvalid = 1'b1;
    bus.w_bdata  = b;
    while (bus.r_bready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got r_bready %b want 1", bus.r_bready);
    end else tick();
    bus.w_bvalid = 1'b0;
  endtask
  task automatic send_word(input int addr, input logic [31:0] w, input int gaps);
    exp_q.push_back({11'(addr), w});
    for (int k = 0; k < 4; k++) begin
      if (gaps > 0) repeat ($urandom_range(0, gaps)) tick();
      send_byte(w[31-8*k -: 8]);
    end
  endtask
  function automatic logic [7:0] csum_of(input int n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < n; i++) c ^= wbuf[i][31:24] ^ wbuf[i][23:16] ^ wbuf[i][15:8] ^ wbuf[i][7:0];
    return c;
  endfunction
  task automatic finish_load(input logic [7:0] cs);
`ifdef CHECKSUM_EN
    send_byte(cs);
`else
    if (cs == 8'hxx) tick(); else tick();
`endif
  endtask
  task automatic chk_done(input string name);
    chk({name, "_done"}, {31'd0, bus.r_done}, 32'd1);
    chk({name, "_busy"}, {31'd0, bus.r_busy}, 32'd0);
    chk({name, "_proc_rst"}, {31'd0, bus.r_proc_rst}, 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int w0;
    bus.w_start = 1'b0;
    bus.w_len = '0;
    bus.w_bvalid = 1'b0;
    bus.w_bdata = '0;
    #12;
    chk("rst_proc_rst", {31'd0, bus.r_proc_rst}, 32'd1);
    chk("rst_bready", {31'd0, bus.r_bready}, 32'd0);
    chk("rst_we", {31'd0, bus.r_we}, 32'd0);
    chk("rst_done", {31'd0, bus.r_done}, 32'd0);
    chk("rst_busy", {31'd0, bus.r_busy}, 32'd0);
    chk("rst_err", {31'd0, bus.r_err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    // Test 1: one word, back-to-back bytes
    start(1);
    chk("t1_busy", {31'd0, bus.r_busy}, 32'd1);
    chk("t1_bready", {31'd0, bus.r_bready}, 32'd1);
    exp_q.push_back({11'd0, 32'h12345678});
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    chk("t1_we", {31'd0, bus.r_we}, 32'd1);
    chk("t1_bready_wr", {31'd0, bus.r_bready}, 32'd0);
    finish_load(8'h08);
    chk_done("t1");
`ifdef CHECKSUM_EN
    chk("t1_err", {31'd0, bus.r_err}, 32'd0);
`endif
    // Test 2: three words with random valid gaps
    w0 = we_cnt;
    start(3);
    wbuf[0] = 32'h10111213;
    wbuf[1] = 32'h14151617;
    wbuf[2] = 32'h18191a1b;
    for (int i = 0; i < 3; i++) send_word(i, wbuf[i], 3);
    finish_load(csum_of(3));
    chk_done("t2");
    chk("t2_we_count", we_cnt - w0, 3);
    // Test 3: reset in the middle of the second word
    start(2);
    send_word(0, 32'hdeadbeef, 0);
    send_byte(8'haa);
    send_byte(8'hbb);
    rst = 1'b1;
    #1;
    chk("t3_we", {31'd0, bus.r_we}, 32'd0);
    chk("t3_bready", {31'd0, bus.r_bready}, 32'd0);
    chk("t3_busy", {31'd0, bus.r_busy}, 32'd0);
    chk("t3_proc_rst", {31'd0, bus.r_proc_rst}, 32'd1);
    tick();
    rst = 1'b0;
    tick();
    start(1);
    wbuf[0] = 32'hcafef00d;
    send_word(0, wbuf[0], 0);
    finish_load(csum_of(1));
    chk_done("t3b");
    // Test 4: zero length, then a clamped full-memory load
    w0 = we_cnt;
    start(0);
    chk_done("t4z");
    repeat (4) tick();
    chk("t4z_we_count", we_cnt - w0, 0);
    for (int i = 0; i < 2048; i++) wbuf[i] = {8'(i), 8'(i >> 8), 8'hc3, ~8'(i)};
    start(4095);
    chk("t4_busy", {31'd0, bus.r_busy}, 32'd1);
    for (int i = 0; i < 2048; i++) send_word(i, wbuf[i], 0);
    finish_load(csum_of(2048));
    chk_done("t4");
    chk("t4_last_addr", {21'd0, bus.r_addr}, 32'h7ff);
    chk("t4_we_count", we_cnt - w0, 2048);
    // Test 5: start ignored during RECV, honoured in DONE
    w0 = we_cnt;
    start(2);
    wbuf[0] = 32'ha1b2c3d4;
    wbuf[1] = 32'h5e6f7081;
    exp_q.push_back({11'd0, wbuf[0]});
    send_byte(8'ha1);
    send_byte(8'hb2);
    start(5);
    chk("t5_busy", {31'd0, bus.r_busy}, 32'd1);
    send_byte(8'hc3);
    send_byte(8'hd4);
    send_word(1, wbuf[1], 0);
    finish_load(csum_of(2));
    chk_done("t5");
    chk("t5_we_count", we_cnt - w0, 2);
    start(1);
    chk("t5_restart_done", {31'd0, bus.r_done}, 32'd0);
    chk("t5_restart_proc_rst", {31'd0, bus.r_proc_rst}, 32'd1);
    chk("t5_restart_busy", {31'd0, bus.r_busy}, 32'd1);
    wbuf[0] = 32'h0badcafe;
    send_word(0, wbuf[0], 1);
    finish_load(csum_of(1));
    chk_done("t5b");
`ifdef CHECKSUM_EN
    // Test 6: checksum match and mismatch
    start(1);
    send_word(0, 32'h01020304, 0);
    send_byte(8'h04);
    chk("t6_err_ok", {31'd0, bus.r_err}, 32'd0);
    chk_done("t6a");
    start(1);
    send_word(0, 32'h01020304, 0);
    send_byte(8'h05);
    chk("t6_err_bad", {31'd0, bus.r_err}, 32'd1);
    chk_done("t6b");
`endif
    repeat (4) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
